// File: rtl/bit_serial_adder_if.sv
// Handshake and operand/result bundle for bit_serial_adder.
//   start      : request to begin an addition (honoured only while idle)
//   A, B, Cin  : operands and carry-in, captured on the accepting edge
//   busy       : high while bit pairs are being processed
//   done       : one-cycle pulse when Sum/Cout carry a fresh result
//   Sum, Cout  : registered result and final carry-out
// master drives the request side; slave is the adder.
interface bit_serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;

  modport master (
    output start, A, B, Cin,
    input  busy, done, Sum, Cout
  );

  modport slave (
    input  start, A, B, Cin,
    output busy, done, Sum, Cout
  );
endinterface

// File: rtl/bit_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one bit pair per clock, LSB first, through a
// full-adder slice built from two half adders and an OR. A carry flop links
// the steps and the sum bits collect in a right-shifting result register.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of bit_serial_adder_if (start/A/B/Cin in,
//           busy/done/Sum/Cout out)
// Sum/Cout change only when an addition completes; busy/done decode state.
module bit_serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  bit_serial_adder_if.slave  bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  // Full-adder slice: two half adders plus an OR for the carry.
  logic ha1_s;
  logic ha1_c;
  logic ha2_s;
  logic ha2_c;
  logic s_bit;
  logic c_bit;

  always_comb begin
    ha1_s = a_sh[0] ^ b_sh[0];
    ha1_c = a_sh[0] & b_sh[0];
    ha2_s = ha1_s ^ carry;
    ha2_c = ha1_s & carry;
    s_bit = ha2_s;
    c_bit = ha1_c | ha2_c;
  end

  // New sum bit enters at the MSB; written as shift-then-set so WIDTH=1
  // needs no special-case slice.
  always_comb begin
    res_next            = res >> 1;
    res_next[WIDTH-1]   = s_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh  <= bus.A;
            b_sh  <= bus.B;
            carry <= bus.Cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          res   <= res_next;
          carry <= c_bit;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum_q  <= res_next;
            cout_q <= c_bit;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.Sum  = sum_q;
  assign bus.Cout = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
module tb_bit_serial_adder;

  localparam int unsigned WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  bit_serial_adder_if #(.WIDTH(WIDTH)) bus ();

  bit_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an operation is described by how many clock edges have
  // passed since it was accepted; the result is plain integer addition.
  int               since = -1;
  logic [WIDTH:0]   pend = '0;
  logic [WIDTH-1:0] exp_sum = '0;
  logic             exp_cout = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      since    <= -1;
      exp_sum  <= '0;
      exp_cout <= 1'b0;
    end else if (since < 0) begin
      if (bus.start) begin
        pend  <= {1'b0, bus.A} + {1'b0, bus.B} + (WIDTH+1)'(bus.Cin);
        since <= 0;
      end
    end else if (since == int'(WIDTH)) begin
      since <= -1;
    end else begin
      since <= since + 1;
      if (since == int'(WIDTH) - 1) begin
        exp_sum  <= pend[WIDTH-1:0];
        exp_cout <= pend[WIDTH];
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("m_busy", 32'(bus.busy), 32'(since >= 0 && since < int'(WIDTH)));
    chk("m_done", 32'(bus.done), 32'(since == int'(WIDTH)));
    chk("m_sum",  32'(bus.Sum),  32'(exp_sum));
    chk("m_cout", 32'(bus.Cout), 32'(exp_cout));
  end

  // One addition with literal expectations: hold = Sum value that must
  // persist during RUN, es/ec = final result.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic [WIDTH-1:0] hold,
                        input logic [WIDTH-1:0] es, input logic ec);
    int nb;
    bit got;
    @(negedge clk);
    bus.A = a; bus.B = b; bus.Cin = cin; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.A = WIDTH'($urandom); bus.B = WIDTH'($urandom); bus.Cin = 1'($urandom);
    chk("sum_hold", 32'(bus.Sum), 32'(hold));
    nb = 0; got = 1'b0;
    for (int i = 0; i < int'(WIDTH) + 4 && !got; i++) begin
      if (bus.busy) nb++;
      if (bus.done) got = 1'b1;
      else @(negedge clk);
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("busy_len", 32'(nb), 32'(WIDTH));
    chk("lit_sum", 32'(bus.Sum), 32'(es));
    chk("lit_cout", 32'(bus.Cout), 32'(ec));
  endtask

  initial begin
    logic [WIDTH-1:0] last_sum;
    logic [WIDTH-1:0] ra, rb, es;
    logic             rc, ec;
    bit               got;

    // Reset held with start asserted and full operands.
    bus.start = 1'b1; bus.A = 8'hFF; bus.B = 8'hFF; bus.Cin = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_sum", 32'(bus.Sum), 32'd0);
    bus.start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_done", 32'(bus.done), 32'd0);

    run_op(8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1);
    run_op(8'hA5, 8'h5A, 1'b1, 8'h00, 8'h00, 1'b1);
    run_op(8'h3C, 8'h0F, 1'b0, 8'h00, 8'h4B, 1'b0);

    // Isolation and start masking: start stays high throughout.
    @(negedge clk);
    bus.A = 8'h12; bus.B = 8'h34; bus.Cin = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    got = 1'b0;
    for (int i = 0; i < int'(WIDTH) + 4 && !got; i++) begin
      bus.A = 8'hFF; bus.B = 8'hFF;
      if (bus.done) got = 1'b1;
      else @(negedge clk);
    end
    chk("iso_done", 32'(got), 32'd1);
    chk("iso_sum", 32'(bus.Sum), 32'h46);
    chk("iso_cout", 32'(bus.Cout), 32'd0);
    @(negedge clk);
    chk("iso_idle", 32'(bus.busy), 32'd0);
    chk("iso_done_once", 32'(bus.done), 32'd0);
    @(negedge clk);
    chk("iso_reaccept", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < int'(WIDTH) + 4 && !got; i++) begin
      if (bus.done) got = 1'b1;
      else @(negedge clk);
    end
    chk("iso2_done", 32'(got), 32'd1);
    chk("iso2_sum", 32'(bus.Sum), 32'hFE);
    chk("iso2_cout", 32'(bus.Cout), 32'd1);

    // Async abort after the 4th RUN edge.
    @(negedge clk);
    bus.A = 8'h77; bus.B = 8'h99; bus.Cin = 1'b1; bus.start = 1'b1;
    @(posedge clk);
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_sum", 32'(bus.Sum), 32'd0);
    chk("abort_cout", 32'(bus.Cout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h80, 8'h80, 1'b1, 8'h00, 8'h01, 1'b1);
    last_sum = 8'h01;

    // Randomized operations.
    for (int n = 0; n < 40; n++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom_range(0, 1));
      {ec, es} = {1'b0, ra} + {1'b0, rb} + 9'(rc);
      run_op(ra, rb, rc, last_sum, es, ec);
      last_sum = es;
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
